zbt_frame_copier: RTL and testbench
===================================

Name: zbt_frame_copier

Overview:
- Parametrised successor to the fixed-geometry ZBT pixel reader.
- Forecasts hcount/vcount LOOKAHEAD clocks ahead and issues word reads to ZBT bank 0.
- Compensates the ZBT read latency with an internal delay line, applies a per-word colour mask, and writes whole frames to ZBT bank 1.
- Frame-aligned start/stop is controlled by a small FSM; it sits between the video timing generator and the two ZBT controllers.

Parameters:
- H_TOTAL, 1056, pixels per line including blanking
- V_TOTAL, 806, lines per frame including blanking
- H_ACTIVE, 1024, active pixels per line
- V_ACTIVE, 768, active lines per frame
- LOOKAHEAD, 8, forecast distance in clocks (must be less than H_TOTAL)
- READ_LAT, 2, ZBT read latency in clocks (must be at least 1)
- PIX_SHIFT, 1, log2(pixels per ZBT word)
- ADDR_W, 19, ZBT address width
- DATA_W, 36, ZBT data width

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- hcount  in  11  current pixel count
- vcount  in  10  current line count
- enable  in  1  request copying; sampled only at frame boundaries
- color_mask  in  DATA_W  ANDed onto every word written
- read_addr  out  ADDR_W  bank 0 read address, registered
- vram_read_data  in  DATA_W  bank 0 read data, valid READ_LAT clocks after the address
- write_addr  out  ADDR_W  bank 1 write address, registered
- write_data  out  DATA_W  bank 1 write data, registered
- write_en  out  1  bank 1 write strobe, one clock per word
- busy  out  1  high in ARMED, COPY and DRAIN
- frame_done  out  1  one-clock pulse after the last word of a frame is written

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, named reset. While reset is high, every output is 0 on the next edge (read_addr, write_addr, write_data, write_en, busy, frame_done), the FSM goes to IDLE, and all delay-line valid bits clear.
- Forecast (combinational):
  - hf = (hcount >= H_TOTAL-LOOKAHEAD) ? hcount-(H_TOTAL-LOOKAHEAD) : hcount+LOOKAHEAD.
  - vf advances only when hcount wraps; it becomes 0 when vcount == V_TOTAL-1, otherwise vcount+1.
- Read issue:
  - issue = (state==COPY) and hf < H_ACTIVE and vf < V_ACTIVE and hf[PIX_SHIFT-1:0]==0.
  - read_addr <= {vf, hf[10:PIX_SHIFT]}, zero-extended or truncated to ADDR_W, registered every clock regardless of issue.
  - Call the clock on which read_addr changes cycle N.
- Latency compensation:
  - A delay line of READ_LAT+1 stages carries {addr, issue}.
  - The data for the cycle-N read is on vram_read_data at N+READ_LAT.
  - On edge N+READ_LAT+1: write_addr <= the same address; write_data <= vram_read_data & color_mask; write_en <= the delayed issue bit.
  - Net latency from issue to write_en is READ_LAT+1 clocks.
  - write_addr and write_data hold their values when write_en is 0.
- FSM:
  - IDLE: when enable=1, go to ARMED.
  - ARMED: when hf==0 and vf==0 (forecast frame start), go to COPY. The first read is issued on that same clock. If enable drops while in ARMED, return to IDLE.
  - COPY: issue reads per the rule above. On the clock issuing the last word (hf == H_ACTIVE-(1<<PIX_SHIFT), vf == V_ACTIVE-1), go to DRAIN. enable is ignored in COPY; a frame is never truncated except by reset.
  - DRAIN: count READ_LAT+1 clocks, then pulse frame_done for one clock coincident with the final write_en. Next state is ARMED if enable=1, else IDLE.
- Boundaries:
  - Horizontal wrap (hcount at H_TOTAL-LOOKAHEAD) and vertical wrap (vcount at V_TOTAL-1) must produce contiguous addresses with no gap or duplicate word.
  - Reset mid-COPY: in-flight words are discarded and no write_en is asserted after reset.
  - enable high at power-up during mid-frame: copying still begins only at the next frame start.
  - color_mask may change at any time; it is applied to whichever word is in the output stage.

Decomposition:
- Shared package zbt_pkg: the FSM state enum (IDLE, ARMED, COPY, DRAIN), default timing constants (1056/806/1024/768), and the ZBT width constants.
- One natural sub-module, zbt_lat_pipe: a parametrised (WIDTH, DEPTH) shift register with a valid bit and synchronous clear, used for the address/issue delay line.

Test Plan:
- Latency: defaults, enable=1, drive a frame. The first read_addr is 0 at cycle N; vram_read_data model returns 36'hABCDE at N+2; expect write_en=1, write_addr=0, write_data=36'hABCDE & mask at N+3.
- Word coverage: full frame with color_mask all ones. Expect exactly 1024*768/2 = 393216 write_en pulses; addresses increase with no gaps, from 0 up to {10'd767, 10'd511}; frame_done pulses once.
- Mask: color_mask=36'h0F0F0F0F0, model data all ones -> every write_data = 36'h0F0F0F0F0.
- Frame alignment: raise enable mid-frame at vcount=300. Expect busy=1 and no write_en until the forecast frame start; drop enable at line 400 of COPY and expect the full frame to complete, then IDLE.
- Reset mid-operation: assert reset at vcount=100 for 1 clock. The next clock has write_en=0 and frame_done=0; no further writes appear until the next frame start (if enable stays high).
- Parameter sweep: READ_LAT=3, PIX_SHIFT=2, LOOKAHEAD=4. Expect issue-to-write latency of 4 clocks, one write per 4 pixels, and correct wrap at hcount=H_TOTAL-4.

Source files
------------

// File: rtl/zbt_pkg.sv
// Shared constants for the ZBT frame copier: FSM state encodings, default
// video timing and ZBT bus widths.
package zbt_pkg;

  localparam int unsigned ZBT_ADDR_W = 19;
  localparam int unsigned ZBT_DATA_W = 36;

  localparam int unsigned HCOUNT_W = 11;
  localparam int unsigned VCOUNT_W = 10;

  localparam int unsigned DEF_H_TOTAL  = 1056;
  localparam int unsigned DEF_V_TOTAL  = 806;
  localparam int unsigned DEF_H_ACTIVE = 1024;
  localparam int unsigned DEF_V_ACTIVE = 768;

  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] ST_ARMED = 2'd1;
  localparam logic [STATE_W-1:0] ST_COPY  = 2'd2;
  localparam logic [STATE_W-1:0] ST_DRAIN = 2'd3;

endpackage

// File: rtl/zbt_lat_pipe.sv
// Fixed-depth shift register carrying a payload plus a valid bit; the valid
// bits clear synchronously so in-flight entries can be discarded.
module zbt_lat_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 3
) (
  input  logic             clk,
  input  logic             clear_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] data_q [DEPTH];

  always_ff @(posedge clk) begin
    if (clear_i) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= valid_i;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
      end
    end
  end

  // Payload needs no clear: it is only consumed alongside its valid bit.
  always_ff @(posedge clk) begin
    data_q[0] <= data_i;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      data_q[i] <= data_q[i-1];
    end
  end

  assign valid_o = valid_q[DEPTH-1];
  assign data_o  = data_q[DEPTH-1];

endmodule

// File: rtl/zbt_frame_copier.sv
// Copies whole video frames from ZBT bank 0 to bank 1: forecasts the raster
// position, issues word reads, realigns returning data and writes it masked.
module zbt_frame_copier
  import zbt_pkg::*;
#(
  parameter int unsigned H_TOTAL   = DEF_H_TOTAL,
  parameter int unsigned V_TOTAL   = DEF_V_TOTAL,
  parameter int unsigned H_ACTIVE  = DEF_H_ACTIVE,
  parameter int unsigned V_ACTIVE  = DEF_V_ACTIVE,
  parameter int unsigned LOOKAHEAD = 8,
  parameter int unsigned READ_LAT  = 2,
  parameter int unsigned PIX_SHIFT = 1,
  parameter int unsigned ADDR_W    = ZBT_ADDR_W,
  parameter int unsigned DATA_W    = ZBT_DATA_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [HCOUNT_W-1:0] hcount,
  input  logic [VCOUNT_W-1:0] vcount,
  input  logic                enable,
  input  logic [DATA_W-1:0]   color_mask,
  output logic [ADDR_W-1:0]   read_addr,
  input  logic [DATA_W-1:0]   vram_read_data,
  output logic [ADDR_W-1:0]   write_addr,
  output logic [DATA_W-1:0]   write_data,
  output logic                write_en,
  output logic                busy,
  output logic                frame_done
);

  localparam int unsigned HC_W   = HCOUNT_W;
  localparam int unsigned VC_W   = VCOUNT_W;
  localparam int unsigned H_WRAP = H_TOTAL - LOOKAHEAD;
  localparam int unsigned CNT_W  = $clog2(READ_LAT + 1) + 1;
  localparam int unsigned DEPTH  = READ_LAT + 1;

  localparam logic [HC_W-1:0] HF_WRAP    = HC_W'(H_WRAP);
  localparam logic [HC_W-1:0] HF_ACTIVE  = HC_W'(H_ACTIVE);
  localparam logic [HC_W-1:0] HF_LAST    = HC_W'(H_ACTIVE - (1 << PIX_SHIFT));
  localparam logic [HC_W-1:0] HF_ALIGN   = HC_W'((1 << PIX_SHIFT) - 1);
  localparam logic [VC_W-1:0] VF_ACTIVE  = VC_W'(V_ACTIVE);
  localparam logic [VC_W-1:0] VF_LAST    = VC_W'(V_ACTIVE - 1);
  localparam logic [VC_W-1:0] VC_LAST    = VC_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] DRAIN_END = CNT_W'(READ_LAT);

  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   drain_cnt_q, drain_cnt_d;
  logic [ADDR_W-1:0]  read_addr_q;
  logic [ADDR_W-1:0]  write_addr_q;
  logic [DATA_W-1:0]  write_data_q;
  logic               write_en_q;
  logic               busy_q;
  logic               frame_done_q, frame_done_d;

  logic [HC_W-1:0]   hf_c;
  logic [VC_W-1:0]   vf_c;
  logic [ADDR_W-1:0] addr_c;
  logic              active_c;
  logic              aligned_c;
  logic              start_c;
  logic              last_c;
  logic              copy_c;
  logic              issue_c;

  logic              pipe_valid;
  logic [ADDR_W-1:0] pipe_addr;

  // Raster position LOOKAHEAD clocks from now; the line only advances on wrap.
  always_comb begin
    hf_c = hcount + HC_W'(LOOKAHEAD);
    vf_c = vcount;
    if (hcount >= HF_WRAP) begin
      hf_c = hcount - HF_WRAP;
      vf_c = (vcount == VC_LAST) ? '0 : vcount + VC_W'(1);
    end
  end

  assign addr_c    = ADDR_W'({vf_c, hf_c[HC_W-1:PIX_SHIFT]});
  assign active_c  = (hf_c < HF_ACTIVE) && (vf_c < VF_ACTIVE);
  assign aligned_c = (hf_c & HF_ALIGN) == '0;
  assign start_c   = (hf_c == '0) && (vf_c == '0);
  assign last_c    = (hf_c == HF_LAST) && (vf_c == VF_LAST);
  assign issue_c   = copy_c && active_c && aligned_c;

  // Frame-aligned copy control; the start-of-frame read issues from ARMED.
  always_comb begin
    state_d      = state_q;
    drain_cnt_d  = drain_cnt_q;
    frame_done_d = 1'b0;
    copy_c       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (start_c) begin
          state_d = ST_COPY;
          copy_c  = 1'b1;
        end
      end
      ST_COPY: begin
        copy_c      = 1'b1;
        drain_cnt_d = '0;
        if (last_c) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (drain_cnt_q == DRAIN_END) begin
          frame_done_d = 1'b1;
          drain_cnt_d  = '0;
          state_d      = enable ? ST_ARMED : ST_IDLE;
        end else begin
          drain_cnt_d = drain_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      drain_cnt_q  <= '0;
      read_addr_q  <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      drain_cnt_q  <= drain_cnt_d;
      read_addr_q  <= addr_c;
      busy_q       <= (state_d != ST_IDLE);
      frame_done_q <= frame_done_d;
    end
  end

  // Address/issue travel alongside the outstanding read until its data returns.
  zbt_lat_pipe #(
    .WIDTH (ADDR_W),
    .DEPTH (DEPTH)
  ) u_lat_pipe (
    .clk     (clk),
    .clear_i (reset),
    .valid_i (issue_c),
    .data_i  (addr_c),
    .valid_o (pipe_valid),
    .data_o  (pipe_addr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      write_addr_q <= '0;
      write_data_q <= '0;
      write_en_q   <= 1'b0;
    end else begin
      write_en_q <= pipe_valid;
      if (pipe_valid) begin
        write_addr_q <= pipe_addr;
        write_data_q <= vram_read_data & color_mask;
      end
    end
  end

  assign read_addr  = read_addr_q;
  assign write_addr = write_addr_q;
  assign write_data = write_data_q;
  assign write_en   = write_en_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_zbt_frame_copier.sv
// Directed bench for zbt_frame_copier: two instances on a reduced raster
// (default-like and a READ_LAT=3/PIX_SHIFT=2/LOOKAHEAD=4 variant) share timing.
module tb_zbt_frame_copier;

  localparam int unsigned HT = 40;
  localparam int unsigned VT = 12;
  localparam int unsigned HA = 32;
  localparam int unsigned VA = 8;
  localparam int unsigned AW = 19;
  localparam int unsigned DW = 36;
  localparam int unsigned FRAME = HT * VT;

  localparam int unsigned LA_A = 8, RL_A = 2, PS_A = 1;
  localparam int unsigned LA_B = 4, RL_B = 3, PS_B = 2;
  localparam int unsigned WPL_A = HA >> PS_A;
  localparam int unsigned WPL_B = HA >> PS_B;
  localparam int unsigned TOT_A = WPL_A * VA;
  localparam int unsigned TOT_B = WPL_B * VA;

  logic          clk = 1'b0;
  logic          reset;
  logic [10:0]   hcount;
  logic [9:0]    vcount;
  logic          enable;
  logic [DW-1:0] color_mask;
  logic          data_ones;
  logic          tgen;

  logic [AW-1:0] raddr_a, waddr_a, raddr_b, waddr_b;
  logic [DW-1:0] vram_a, wdata_a, vram_b, wdata_b;
  logic          wen_a, busy_a, fd_a, wen_b, busy_b, fd_b;

  int n_checks = 0;
  int n_fail   = 0;
  int cnt_a = 0, cnt_b = 0;
  int frames_a = 0, frames_b = 0;
  int wtot_a = 0, wtot_b = 0;

  always #5 clk = ~clk;

  zbt_frame_copier #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA),
    .LOOKAHEAD(LA_A), .READ_LAT(RL_A), .PIX_SHIFT(PS_A),
    .ADDR_W(AW), .DATA_W(DW)
  ) u_a (
    .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
    .enable(enable), .color_mask(color_mask), .read_addr(raddr_a),
    .vram_read_data(vram_a), .write_addr(waddr_a), .write_data(wdata_a),
    .write_en(wen_a), .busy(busy_a), .frame_done(fd_a)
  );

  zbt_frame_copier #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA),
    .LOOKAHEAD(LA_B), .READ_LAT(RL_B), .PIX_SHIFT(PS_B),
    .ADDR_W(AW), .DATA_W(DW)
  ) u_b (
    .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
    .enable(enable), .color_mask(color_mask), .read_addr(raddr_b),
    .vram_read_data(vram_b), .write_addr(waddr_b), .write_data(wdata_b),
    .write_en(wen_b), .busy(busy_b), .frame_done(fd_b)
  );

  function automatic logic [DW-1:0] pix(input logic [AW-1:0] a);
    pix = data_ones ? {DW{1'b1}} : (DW'(36'hABCDE) + DW'(a));
  endfunction

  // Bank 0 model: data for an address appears READ_LAT clocks later.
  logic [DW-1:0] dl_a [RL_A];
  logic [DW-1:0] dl_b [RL_B];
  always @(posedge clk) begin
    dl_a[0] <= pix(raddr_a);
    for (int i = 1; i < int'(RL_A); i++) dl_a[i] <= dl_a[i-1];
    dl_b[0] <= pix(raddr_b);
    for (int i = 1; i < int'(RL_B); i++) dl_b[i] <= dl_b[i-1];
  end
  assign vram_a = dl_a[RL_A-1];
  assign vram_b = dl_b[RL_B-1];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // One clock: sample after the edge, score writes, then advance the raster.
  task automatic step();
    logic [AW-1:0] ea;
    @(posedge clk);
    #1;
    if (wen_a) begin
      wtot_a++;
      ea = AW'({10'(cnt_a / int'(WPL_A)), 10'(cnt_a % int'(WPL_A))});
      chk("a_write_in_frame", 64'(cnt_a < int'(TOT_A)), 64'd1);
      chk("a_write_addr", 64'(waddr_a), 64'(ea));
      chk("a_write_data", 64'(wdata_a), 64'(pix(ea) & color_mask));
      cnt_a++;
    end
    if (fd_a) begin
      chk("a_done_with_wen", 64'(wen_a), 64'd1);
      chk("a_frame_words", 64'(cnt_a), 64'(TOT_A));
      cnt_a = 0;
      frames_a++;
    end
    if (wen_b) begin
      wtot_b++;
      ea = AW'({10'(cnt_b / int'(WPL_B)), 9'(cnt_b % int'(WPL_B))});
      chk("b_write_in_frame", 64'(cnt_b < int'(TOT_B)), 64'd1);
      chk("b_write_addr", 64'(waddr_b), 64'(ea));
      chk("b_write_data", 64'(wdata_b), 64'(pix(ea) & color_mask));
      cnt_b++;
    end
    if (fd_b) begin
      chk("b_done_with_wen", 64'(wen_b), 64'd1);
      chk("b_frame_words", 64'(cnt_b), 64'(TOT_B));
      cnt_b = 0;
      frames_b++;
    end
    if (tgen) begin
      if (hcount == 11'(HT - 1)) begin
        hcount = '0;
        vcount = (vcount == 10'(VT - 1)) ? '0 : vcount + 10'd1;
      end else begin
        hcount = hcount + 11'd1;
      end
    end
  endtask

  task automatic wait_pos(input int h, input int v);
    for (int i = 0; i < int'(3 * FRAME); i++) begin
      if (hcount == 11'(h) && vcount == 10'(v)) break;
      step();
    end
    chk("wait_pos_timeout", 64'(hcount == 11'(h) && vcount == 10'(v)), 64'd1);
  endtask

  task automatic wait_frames(input int ta, input int tb);
    for (int i = 0; i < int'(3 * FRAME); i++) begin
      if (frames_a >= ta && frames_b >= tb) break;
      step();
    end
    chk("frame_done_timeout", 64'(frames_a >= ta && frames_b >= tb), 64'd1);
  endtask

  typedef struct {
    logic [10:0]   h;
    logic [9:0]    v;
    logic [AW-1:0] ea;
    logic [AW-1:0] eb;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int sa, sb;

    // Forecast vectors around both horizontal wrap points and the vertical wrap.
    vecs[0] = '{11'd0,  10'd0,  19'd4,     19'd1};
    vecs[1] = '{11'd31, 10'd3,  19'd3091,  19'd1544};
    vecs[2] = '{11'd32, 10'd3,  19'd4096,  19'd1545};
    vecs[3] = '{11'd35, 10'd5,  19'd6145,  19'd2569};
    vecs[4] = '{11'd36, 10'd5,  19'd6146,  19'd3072};
    vecs[5] = '{11'd39, 10'd11, 19'd3,     19'd0};
    vecs[6] = '{11'd24, 10'd11, 19'd11280, 19'd5639};
    vecs[7] = '{11'd38, 10'd10, 19'd11267, 19'd5632};

    reset = 1'b1; enable = 1'b0; color_mask = {DW{1'b1}}; data_ones = 1'b0;
    tgen = 1'b0; hcount = 11'd20; vcount = 10'd2;
    step();
    step();
    chk("rst_raddr_a", 64'(raddr_a), 64'd0);
    chk("rst_waddr_a", 64'(waddr_a), 64'd0);
    chk("rst_wdata_a", 64'(wdata_a), 64'd0);
    chk("rst_wen_a",   64'(wen_a),   64'd0);
    chk("rst_busy_a",  64'(busy_a),  64'd0);
    chk("rst_done_a",  64'(fd_a),    64'd0);
    chk("rst_raddr_b", 64'(raddr_b), 64'd0);
    chk("rst_wen_b",   64'(wen_b),   64'd0);
    chk("rst_busy_b",  64'(busy_b),  64'd0);
    chk("rst_done_b",  64'(fd_b),    64'd0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      hcount = vecs[i].h;
      vcount = vecs[i].v;
      step();
      chk($sformatf("vec%0d_raddr_a", i), 64'(raddr_a), 64'(vecs[i].ea));
      chk($sformatf("vec%0d_raddr_b", i), 64'(raddr_b), 64'(vecs[i].eb));
      chk($sformatf("vec%0d_idle_wen", i), 64'(wen_a | wen_b), 64'd0);
    end

    // Enable mid-frame; copying must wait for the forecast frame start.
    hcount = 11'd0; vcount = 10'd5; tgen = 1'b1; enable = 1'b1;
    step();
    chk("armed_busy_a", 64'(busy_a), 64'd1);
    chk("armed_busy_b", 64'(busy_b), 64'd1);
    sa = wtot_a; sb = wtot_b;
    wait_pos(int'(HT - LA_A), int'(VT - 1));
    chk("armed_no_write_a", 64'(wtot_a - sa), 64'd0);
    chk("armed_no_write_b", 64'(wtot_b - sb), 64'd0);

    step();
    chk("lat_a_first_raddr", 64'(raddr_a), 64'd0);
    chk("lat_a_wen_N", 64'(wen_a), 64'd0);
    for (int k = 1; k <= int'(RL_A); k++) begin
      step();
      chk($sformatf("lat_a_wen_N+%0d", k), 64'(wen_a), 64'd0);
    end
    step();
    chk("lat_a_wen",   64'(wen_a),   64'd1);
    chk("lat_a_waddr", 64'(waddr_a), 64'd0);
    chk("lat_a_wdata", 64'(wdata_a), 64'(36'hABCDE));

    // Inputs now sit at the B instance's forecast frame start.
    step();
    chk("lat_b_first_raddr", 64'(raddr_b), 64'd0);
    chk("lat_b_wen_N", 64'(wen_b), 64'd0);
    for (int k = 1; k <= int'(RL_B); k++) begin
      step();
      chk($sformatf("lat_b_wen_N+%0d", k), 64'(wen_b), 64'd0);
    end
    step();
    chk("lat_b_wen",   64'(wen_b),   64'd1);
    chk("lat_b_waddr", 64'(waddr_b), 64'd0);
    chk("lat_b_wdata", 64'(wdata_b), 64'(36'hABCDE));

    wait_frames(1, 1);
    chk("cov_frames_a", 64'(frames_a), 64'd1);
    chk("cov_frames_b", 64'(frames_b), 64'd1);
    chk("cov_total_a", 64'(wtot_a), 64'(TOT_A));
    chk("cov_total_b", 64'(wtot_b), 64'(TOT_B));
    chk("rearm_busy_a", 64'(busy_a), 64'd1);

    // Colour mask over all-ones data.
    data_ones = 1'b1;
    color_mask = 36'h0F0F0F0F0;
    wait_frames(2, 2);
    chk("mask_last_a", 64'(wdata_a), 64'(36'h0F0F0F0F0));
    chk("mask_last_b", 64'(wdata_b), 64'(36'h0F0F0F0F0));
    data_ones = 1'b0;
    color_mask = {DW{1'b1}};

    // One-clock reset in the middle of a copy.
    wait_pos(0, 3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_mid_wen_a",  64'(wen_a),  64'd0);
    chk("rst_mid_done_a", 64'(fd_a),   64'd0);
    chk("rst_mid_busy_a", 64'(busy_a), 64'd0);
    chk("rst_mid_wen_b",  64'(wen_b),  64'd0);
    chk("rst_mid_done_b", 64'(fd_b),   64'd0);
    cnt_a = 0; cnt_b = 0;
    sa = wtot_a; sb = wtot_b;
    wait_pos(int'(HT - LA_A), int'(VT - 1));
    chk("rst_no_write_a", 64'(wtot_a - sa), 64'd0);
    chk("rst_no_write_b", 64'(wtot_b - sb), 64'd0);
    wait_frames(3, 3);

    // Dropping enable mid-copy must not truncate the frame.
    wait_pos(0, 4);
    enable = 1'b0;
    step();
    chk("drop_busy_a", 64'(busy_a), 64'd1);
    chk("drop_busy_b", 64'(busy_b), 64'd1);
    wait_frames(4, 4);
    for (int k = 0; k < 5; k++) step();
    chk("idle_busy_a", 64'(busy_a), 64'd0);
    chk("idle_busy_b", 64'(busy_b), 64'd0);
    sa = wtot_a; sb = wtot_b;
    for (int k = 0; k < int'(FRAME); k++) step();
    chk("idle_no_write_a", 64'(wtot_a - sa), 64'd0);
    chk("idle_no_write_b", 64'(wtot_b - sb), 64'd0);

    // Re-enable mid-frame from IDLE.
    wait_pos(0, 4);
    enable = 1'b1;
    step();
    chk("reen_busy_a", 64'(busy_a), 64'd1);
    chk("reen_busy_b", 64'(busy_b), 64'd1);
    sa = wtot_a; sb = wtot_b;
    wait_pos(int'(HT - LA_A), int'(VT - 1));
    chk("reen_no_write_a", 64'(wtot_a - sa), 64'd0);
    chk("reen_no_write_b", 64'(wtot_b - sb), 64'd0);
    wait_frames(5, 5);
    chk("final_frames_a", 64'(frames_a), 64'd5);
    chk("final_frames_b", 64'(frames_b), 64'd5);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
